move_scan_ctrl: RTL and testbench

MOVE_SCAN_CTRL -- requirements
Module: move_scan_ctrl

---
 rtl/move_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_move_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scan_ctrl.sv
// Move-generation scan sequencer: clears and settles the square array, then walks every
// square/direction slot and hands each valid move to the consumer through a valid/ready port.
module move_scan_ctrl #(
    parameter int NUM_SQ        = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        engineColor,
    input  logic        abort,
    output logic        sq_clear,
    output logic        sq_enable,
    output logic        sq_color,
    output logic [5:0]  sq_sel,
    output logic [3:0]  dir_sel,
    input  logic [31:0] move_in,
    output logic [31:0] move_out,
    output logic        move_valid,
    input  logic        move_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  move_count
);

    localparam logic [5:0] LAST_SQ     = 6'(NUM_SQ - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_sq_clear;
    logic        r_sq_enable;
    logic        r_sq_color;
    logic [5:0]  r_sq_sel;
    logic [3:0]  r_dir_sel;
    logic [3:0]  r_settle_cnt;
    logic [31:0] r_move_out;
    logic        r_move_valid;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_move_count;

    logic        w_slot_valid;
    logic        w_last_slot;
    logic [5:0]  w_next_sq;
    logic [3:0]  w_next_dir;
    logic [7:0]  w_count_inc;

    // A slot carries a move only if it is non-empty and its moving piece belongs to the side to move.
    assign w_slot_valid = (move_in != 32'd0) && (move_in[13] == r_sq_color);
    assign w_last_slot  = (r_sq_sel == LAST_SQ) && (r_dir_sel == 4'hF);
    assign w_next_dir   = r_dir_sel + 4'd1;
    assign w_next_sq    = (r_dir_sel == 4'hF) ? r_sq_sel + 6'd1 : r_sq_sel;
    assign w_count_inc  = (r_move_count == 8'hFF) ? r_move_count : r_move_count + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sq_clear   <= 1'b0;
            r_sq_enable  <= 1'b0;
            r_sq_color   <= 1'b0;
            r_sq_sel     <= 6'd0;
            r_dir_sel    <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_move_out   <= 32'd0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_move_count <= 8'd0;
        end else if (abort && r_busy) begin
            // Abort discards any pending move; move_count keeps whatever was already counted.
            r_state      <= S_DONE;
            r_sq_clear   <= 1'b0;
            r_sq_enable  <= 1'b0;
            r_move_out   <= 32'd0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_CLEAR;
                        r_sq_clear   <= 1'b1;
                        r_sq_color   <= engineColor;
                        r_sq_sel     <= 6'd0;
                        r_dir_sel    <= 4'd0;
                        r_move_count <= 8'd0;
                        r_busy       <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state      <= S_SETTLE;
                    r_sq_clear   <= 1'b0;
                    r_sq_enable  <= 1'b1;
                    r_settle_cnt <= 4'd0;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state     <= S_SCAN;
                        r_sq_enable <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                S_SCAN: begin
                    if (w_slot_valid) begin
                        r_state      <= S_EMIT;
                        r_move_out   <= move_in;
                        r_move_valid <= 1'b1;
                        r_move_count <= w_count_inc;
                    end else if (w_last_slot) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_sq_sel  <= w_next_sq;
                        r_dir_sel <= w_next_dir;
                    end
                end
                S_EMIT: begin
                    // Indices stay frozen on the emitted slot until the consumer takes the move.
                    if (move_ready) begin
                        r_move_valid <= 1'b0;
                        if (w_last_slot) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_SCAN;
                            r_sq_sel  <= w_next_sq;
                            r_dir_sel <= w_next_dir;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sq_clear   = r_sq_clear;
    assign sq_enable  = r_sq_enable;
    assign sq_color   = r_sq_color;
    assign sq_sel     = r_sq_sel;
    assign dir_sel    = r_dir_sel;
    assign move_out   = r_move_out;
    assign move_valid = r_move_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_move_scan_ctrl.sv
// Scoreboard bench for move_scan_ctrl: directed passes push expected transfers/done pulses,
// a monitor pops and compares them whenever the DUT completes a handshake or pulses done.
module tb_move_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        engineColor;
    logic        abort;
    logic        sq_clear;
    logic        sq_enable;
    logic        sq_color;
    logic [5:0]  sq_sel;
    logic [3:0]  dir_sel;
    logic [31:0] move_in;
    logic [31:0] move_out;
    logic        move_valid;
    logic        move_ready;
    logic        busy;
    logic        done;
    logic [7:0]  move_count;

    // Board model: a single non-empty slot at (tgt_sq, tgt_dir) when tgt_en is set.
    logic        tgt_en;
    logic [5:0]  tgt_sq;
    logic [3:0]  tgt_dir;
    logic [31:0] tgt_word;

    int n_chk  = 0;
    int n_fail = 0;

    logic [39:0] exp_xfer[$];
    logic [7:0]  exp_done[$];

    move_scan_ctrl #(.NUM_SQ(64), .SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .engineColor(engineColor),
        .abort      (abort),
        .sq_clear   (sq_clear),
        .sq_enable  (sq_enable),
        .sq_color   (sq_color),
        .sq_sel     (sq_sel),
        .dir_sel    (dir_sel),
        .move_in    (move_in),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .busy       (busy),
        .done       (done),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        move_in = 32'd0;
        if (tgt_en && sq_sel == tgt_sq && dir_sel == tgt_dir) move_in = tgt_word;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake that will complete at the next edge, or a done pulse.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (move_valid && move_ready && !abort) begin
                if (exp_xfer.size() == 0) chk("unexpected_transfer", {move_out, move_count}, 40'd0);
                else chk("transfer", {move_out, move_count}, exp_xfer.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", {56'd0, move_count}, 64'hDEAD);
                else chk("done_count", {56'd0, move_count}, {56'd0, exp_done.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic color);
        engineColor = color;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k = 0;
        @(negedge clk);
        while (!done && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, {63'd0, done}, 64'd1);
        step();
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int k = 0;
        @(negedge clk);
        while (!move_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, {63'd0, move_valid}, 64'd1);
    endtask

    initial begin
        logic [31:0] held_out;
        int first_done;
        int n_done;
        int n_valid;
        int k;

        reset_n = 1'b0; start = 1'b0; engineColor = 1'b0; abort = 1'b0; move_ready = 1'b1;
        tgt_en = 1'b0; tgt_sq = 6'd20; tgt_dir = 4'd1; tgt_word = 32'h0013_1114;
        step(); step();
        @(negedge clk);
        chk("reset_outputs", {31'd0, sq_clear, sq_enable, sq_color, sq_sel, dir_sel, move_valid, busy, done, move_count},
            64'd0);
        chk("reset_move_out", {32'd0, move_out}, 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // Empty board: cycle-exact sequencing of clear, settle, scan and done.
        exp_done.push_back(8'd0);
        engineColor = 1'b0;
        start = 1'b1;
        step();                      // edge E0
        start = 1'b0;
        first_done = 0; n_done = 0;
        for (int cyc = 1; cyc <= 1035; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("c1_clear", {62'd0, sq_clear, sq_enable}, 64'b10);
            if (cyc == 2 || cyc == 3) chk("settle_enable", {62'd0, sq_clear, sq_enable}, 64'b01);
            if (cyc == 4) chk("scan_start", {50'd0, sq_clear, sq_enable, busy, sq_sel, dir_sel, 1'b0}, {50'd0, 3'b001, 11'd0});
            if (cyc == 1027) chk("last_slot", {53'd0, busy, sq_sel, dir_sel}, {53'd0, 1'b1, 6'd63, 4'd15});
            if (done) begin
                if (first_done == 0) first_done = cyc;
                n_done++;
                chk("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
        chk("done_cycle", 64'(first_done), 64'd1028);
        chk("done_width", 64'(n_done), 64'd1);
        step();

        // One black move at square 20 / direction 1.
        tgt_en = 1'b1;
        exp_xfer.push_back({32'h0013_1114, 8'd1});
        exp_done.push_back(8'd1);
        start_pass(1'b0);
        wait_done("pass_black_done", 1100);
        chk("pass_black_count", {56'd0, move_count}, 64'd1);

        // Same board, white to move: the slot's piece is the wrong colour.
        exp_done.push_back(8'd0);
        start_pass(1'b1);
        n_valid = 0; k = 0;
        @(negedge clk);
        while (!done && k < 1100) begin
            if (move_valid) n_valid++;
            @(negedge clk);
            k++;
        end
        chk("white_done", {63'd0, done}, 64'd1);
        chk("white_no_valid", 64'(n_valid), 64'd0);
        step();

        // Back-pressure: move held stable and indices frozen while ready is low.
        move_ready = 1'b0;
        start_pass(1'b0);
        wait_valid("stall_valid", 400);
        held_out = move_out;
        chk("stall_word", {32'd0, held_out}, {32'd0, 32'h0013_1114});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {move_out, 21'd0, move_valid, sq_sel, dir_sel}, {held_out, 21'd0, 1'b1, 6'd20, 4'd1});
        end
        exp_xfer.push_back({32'h0013_1114, 8'd1});
        exp_done.push_back(8'd1);
        step();
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        @(negedge clk);
        chk("after_xfer", {53'd0, move_valid, sq_sel, dir_sel}, {53'd0, 1'b0, 6'd20, 4'd2});
        move_ready = 1'b1;
        wait_done("stall_done", 1100);

        // Abort while a move is pending, with ready asserted in the same cycle.
        move_ready = 1'b0;
        start_pass(1'b0);
        wait_valid("abort_valid", 400);
        step();
        start = 1'b1; engineColor = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored", {52'd0, busy, sq_color, move_valid, sq_sel, dir_sel}, {52'd0, 3'b101, 6'd20, 4'd1});
        exp_done.push_back(8'd1);
        step();
        abort = 1'b1; move_ready = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_done", {61'd0, done, busy, move_valid}, 64'b100);
        step(); step(); step();
        @(negedge clk);
        chk("count_held", {55'd0, done, move_count}, {55'd0, 1'b0, 8'd1});
        step();

        // Mid-scan reset, then a clean full pass.
        tgt_en = 1'b0;
        start_pass(1'b1);
        k = 0;
        @(negedge clk);
        while (sq_sel != 6'd30 && k < 800) begin
            @(negedge clk);
            k++;
        end
        chk("reach_sq30", {58'd0, sq_sel}, 64'd30);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {31'd0, sq_clear, sq_enable, sq_color, sq_sel, dir_sel, move_valid, busy, done, move_count},
            64'd0);
        chk("midreset_move_out", {32'd0, move_out}, 64'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        exp_done.push_back(8'd0);
        start_pass(1'b0);
        for (int i = 0; i < 3; i++) @(negedge clk);
        @(negedge clk);
        chk("restart_scan", {53'd0, busy, sq_sel, dir_sel}, {53'd0, 1'b1, 6'd0, 4'd0});
        wait_done("restart_done", 1100);

        step(); step();
        chk("xfer_queue_empty", 64'(exp_xfer.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
